// File: rtl/simd_alu_pipe.sv
// Two-stage pipelined ALU with scalar ops and packed-lane wrap/saturating add/sub.
// Valid/ready on both sides; sticky saturation flag for DSP kernels.

module simd_alu_lane #(
    parameter int LANE = 8
) (
    input  logic [LANE-1:0] a,
    input  logic [LANE-1:0] b,
    input  logic            sub,
    input  logic            usat,
    input  logic            ssat,
    output logic [LANE-1:0] r,
    output logic            sat
);
    logic [LANE:0] u, s;

    always_comb begin
        u   = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        s   = sub ? ({a[LANE-1], a} - {b[LANE-1], b}) : ({a[LANE-1], a} + {b[LANE-1], b});
        r   = u[LANE-1:0];
        sat = 1'b0;
        // Carry-out of the zero-extended sum is overflow for add and borrow for sub.
        if (usat && u[LANE]) begin
            sat = 1'b1;
            r   = sub ? '0 : '1;
        end else if (ssat && (s[LANE] ^ s[LANE-1])) begin
            sat = 1'b1;
            r   = s[LANE] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
        end
    end
endmodule

module simd_alu_pipe #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic             sat,
    output logic             sat_sticky,
    input  logic             clr_sat
);
    localparam int NL  = WIDTH / LANE;
    localparam int SHW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       op;
    } req_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             sat;
    } rsp_t;

    req_t s1;
    rsp_t s2, alu;
    logic [2:1] vld_pipe;
    logic s1_adv, s2_adv;

    logic [NL-1:0][LANE-1:0] la, lb, lr;
    logic [NL-1:0]           lsat;
    logic                    p_sub, p_usat, p_ssat;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        res;
    logic                    sat_c;

    assign s2_adv   = !vld_pipe[2] | out_ready;
    assign s1_adv   = !vld_pipe[1] | s2_adv;
    assign in_ready = s1_adv;

    assign la     = s1.a;
    assign lb     = s1.b;
    assign sh     = s1.a[SHW-1:0];
    assign p_sub  = (s1.op == 4'b1110) || (s1.op == 4'b1111);
    assign p_usat = (s1.op == 4'b1001) || (s1.op == 4'b1110);
    assign p_ssat = (s1.op == 4'b1101) || (s1.op == 4'b1111);

    for (genvar g = 0; g < NL; g++) begin : g_lane
        simd_alu_lane #(.LANE(LANE)) u_lane (
            .a    (la[g]),
            .b    (lb[g]),
            .sub  (p_sub),
            .usat (p_usat),
            .ssat (p_ssat),
            .r    (lr[g]),
            .sat  (lsat[g])
        );
    end

    always_comb begin
        res   = '0;
        sat_c = 1'b0;
        case (s1.op)
            4'b0010: res = s1.a + s1.b;
            4'b0110: res = s1.a - s1.b;
            4'b0000: res = s1.a & s1.b;
            4'b0001: res = s1.a | s1.b;
            4'b0011: res = s1.a ^ s1.b;
            4'b0100: res = ~(s1.a | s1.b);
            4'b0111: res = {{(WIDTH-1){1'b0}}, $signed(s1.a) < $signed(s1.b)};
            4'b0101: res = {{(WIDTH-1){1'b0}}, s1.a < s1.b};
            4'b1010: res = s1.b << sh;
            4'b1011: res = s1.b >> sh;
            4'b1100: res = $signed(s1.b) >>> sh;
            4'b1000, 4'b1001, 4'b1101, 4'b1110, 4'b1111: begin
                res   = lr;
                sat_c = |lsat;
            end
            default: res = '0;
        endcase
        alu.res  = res;
        alu.zero = (res == '0);
        alu.sat  = sat_c;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe   <= '0;
            s1         <= '0;
            s2         <= '0;
            sat_sticky <= 1'b0;
        end else begin
            if (s1_adv) vld_pipe[1] <= in_valid;
            if (s1_adv && in_valid) s1 <= '{a: SrcA, b: SrcB, op: ALUControl};
            if (s2_adv) vld_pipe[2] <= vld_pipe[1];
            if (s2_adv && vld_pipe[1]) s2 <= alu;
            // A saturating delivery beats a simultaneous clear.
            if (vld_pipe[2] && out_ready && s2.sat) sat_sticky <= 1'b1;
            else if (clr_sat)                      sat_sticky <= 1'b0;
        end
    end

    assign out_valid = vld_pipe[2];
    assign ALUResult = s2.res;
    assign zero      = s2.zero;
    assign sat       = s2.sat;
endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench for simd_alu_pipe: driver pushes expected beats, monitor pops on delivery.

module tb_simd_alu_pipe;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] SrcA, SrcB, ALUResult;
    logic [3:0]  ALUControl;
    logic        zero, sat, sat_sticky, clr_sat;

    int n_chk  = 0;
    int n_fail = 0;
    logic [33:0] sb[$];

    simd_alu_pipe #(.WIDTH(32), .LANE(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .zero       (zero),
        .sat        (sat),
        .sat_sticky (sat_sticky),
        .clr_sat    (clr_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a beat is delivered at the next posedge when valid & ready at negedge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", ALUResult, 32'hxxxxxxxx);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                chk("result", ALUResult, e[33:2]);
                chk("zero", {31'b0, zero}, {31'b0, e[1]});
                chk("sat", {31'b0, sat}, {31'b0, e[0]});
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] er, input logic es);
        int t;
        in_valid   = 1'b1;
        SrcA       = a;
        SrcB       = b;
        ALUControl = op;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 50) begin
                chk("accept_timeout", {31'b0, in_ready}, 32'd1);
                break;
            end
        end
        sb.push_back({er, er == 32'h0, es});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        clr_sat    = 1'b0;
        SrcA       = '0;
        SrcB       = '0;
        ALUControl = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_sat", {31'b0, sat}, 32'd0);
        chk("rst_sticky", {31'b0, sat_sticky}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Latency: accepted at edge E0, visible after E1.
        send(32'h5, 32'h3, 4'b0010, 32'h8, 1'b0);
        @(negedge clk);
        chk("lat_n1_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_n2_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        send(32'h5, 32'h5, 4'b0110, 32'h0, 1'b0);
        send(32'hFFFFFFFF, 32'h1, 4'b0111, 32'h1, 1'b0);
        send(32'hFFFFFFFF, 32'h1, 4'b0101, 32'h0, 1'b0);
        send(32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'hF000F000, 1'b0);
        send(32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 32'hFFF0FFF0, 1'b0);
        send(32'hF0F0F0F0, 32'hFF00FF00, 4'b0011, 32'h0FF00FF0, 1'b0);
        send(32'hF0F0F0F0, 32'hFF00FF00, 4'b0100, 32'h000F000F, 1'b0);
        send(32'h24, 32'h80000000, 4'b1100, 32'hF8000000, 1'b0);
        send(32'h1F, 32'h00000001, 4'b1010, 32'h80000000, 1'b0);
        send(32'hFFFFFFE4, 32'h80000000, 4'b1011, 32'h08000000, 1'b0);
        drain();
        chk("sticky_clean", {31'b0, sat_sticky}, 32'd0);

        send(32'hF0807F01, 32'h20807F01, 4'b1000, 32'h1000FE02, 1'b0);
        send(32'hF0807F01, 32'h20807F01, 4'b1001, 32'hFFFFFE02, 1'b1);
        send(32'hF0807F01, 32'h20807F01, 4'b1101, 32'h10807F02, 1'b1);
        drain();
        chk("sticky_set", {31'b0, sat_sticky}, 32'd1);

        clr_sat = 1'b1;
        @(posedge clk);
        #1;
        chk("sticky_clr", {31'b0, sat_sticky}, 32'd0);

        // Saturating delivery with clr_sat held: set must win.
        send(32'h80000000, 32'h01010101, 4'b1111, 32'h80FFFFFF, 1'b1);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk);
        #1;
        clr_sat = 1'b0;
        chk("sticky_set_wins", {31'b0, sat_sticky}, 32'd1);
        send(32'h01020304, 32'h02020202, 4'b1110, 32'h00000102, 1'b1);
        drain();

        // Back-pressure: two beats fill the pipe, then in_ready drops.
        out_ready = 1'b0;
        send(32'h1, 32'h1, 4'b0010, 32'h2, 1'b0);
        send(32'h2, 32'h2, 4'b0010, 32'h4, 1'b0);
        @(negedge clk);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_hold_result", ALUResult, 32'h2);
        @(posedge clk);
        #1;
        fork
            begin
                send(32'hA, 32'h3, 4'b0110, 32'h7, 1'b0);
                send(32'h0F0F0F0F, 32'h0000FFFF, 4'b0011, 32'h0F0FF0F0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-stream discards in-flight beats and the sticky flag.
        out_ready = 1'b0;
        send(32'h0, 32'h01010101, 4'b1110, 32'h0, 1'b1);
        send(32'h3, 32'h4, 4'b0010, 32'h7, 1'b0);
        @(negedge clk);
        chk("pre_rst_sticky", {31'b0, sat_sticky}, 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_sticky", {31'b0, sat_sticky}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        send(32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
